// File: rtl/des_pkg.sv
// des_pkg: DES tables, permutation/rotation helpers and the FSM encoding
// shared by the iterative decrypt core (and the encrypt path).
// Vectors are declared [N:1] with index N holding FIPS 46 bit 1, so FIPS
// bit k of an N-bit vector lives at index N+1-k.
package des_pkg;

  localparam int ROUNDS = 16;

  // The 4-bit round counter holds 1..16; round 16 wraps to 0.
  localparam logic [3:0] RND_LAST = 4'(ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Row-major: entry index = row*16 + column.
  localparam int SBOX_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [64:1] des_ip(input logic [64:1] x);
    logic [64:1] y;
    for (int i = 1; i <= 64; i++) y[65-i] = x[65-IP_T[i-1]];
    return y;
  endfunction

  function automatic logic [64:1] des_fp(input logic [64:1] x);
    logic [64:1] y;
    for (int i = 1; i <= 64; i++) y[65-i] = x[65-FP_T[i-1]];
    return y;
  endfunction

  function automatic logic [48:1] des_e(input logic [32:1] x);
    logic [48:1] y;
    for (int i = 1; i <= 48; i++) y[49-i] = x[33-E_T[i-1]];
    return y;
  endfunction

  function automatic logic [32:1] des_p(input logic [32:1] x);
    logic [32:1] y;
    for (int i = 1; i <= 32; i++) y[33-i] = x[33-P_T[i-1]];
    return y;
  endfunction

  // Parity bits 8,16,...,64 are simply never selected.
  function automatic logic [56:1] des_pc1(input logic [64:1] x);
    logic [56:1] y;
    for (int i = 1; i <= 56; i++) y[57-i] = x[65-PC1_T[i-1]];
    return y;
  endfunction

  function automatic logic [48:1] des_pc2(input logic [56:1] x);
    logic [48:1] y;
    for (int i = 1; i <= 48; i++) y[49-i] = x[57-PC2_T[i-1]];
    return y;
  endfunction

  // Outer bits select the row, inner four bits the column.
  function automatic logic [3:0] des_sbox(input logic [2:0] idx, input logic [6:1] b);
    int v;
    v = SBOX_T[idx][{b[6], b[1], b[5:2]}];
    return v[3:0];
  endfunction

  // Decrypt walks the schedule backwards: no move for K16, then undo each
  // left shift in reverse. Encrypt uses the standard left-shift amounts.
  function automatic logic [1:0] des_rot_amt(input logic [3:0] rnd, input logic enc);
    logic [1:0] amt;
    case (rnd)
      4'd1:               amt = enc ? 2'd1 : 2'd0;
      4'd2, 4'd9, RND_LAST: amt = 2'd1;
      default:            amt = 2'd2;
    endcase
    return amt;
  endfunction

  // Right rotation moves bits toward higher FIPS numbers.
  function automatic logic [28:1] des_rotr(input logic [28:1] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[1], x[28:2]};
      2'd2:    return {x[2:1], x[28:3]};
      default: return x;
    endcase
  endfunction

  function automatic logic [28:1] des_rotl(input logic [28:1] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[27:1], x[28]};
      2'd2:    return {x[26:1], x[28:27]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_round_f.sv
// des_round_f: combinational DES round function f(R, K) =
// P(S1..S8(E(R) ^ K)). S-box i consumes FIPS bits 6(i-1)+1..6i.
module des_round_f
  import des_pkg::*;
(
  input  logic [32:1] r,
  input  logic [48:1] subkey,
  output logic [32:1] f
);

  logic [48:1] x;
  logic [32:1] s_out;

  assign x = des_e(r) ^ subkey;

  for (genvar i = 1; i <= 8; i++) begin : g_sbox
    assign s_out[36-4*i -: 4] = des_sbox(3'(i - 1), x[54-6*i -: 6]);
  end

  assign f = des_p(s_out);

endmodule

// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES decryption, one Feistel round per clock.
// Subkeys K16..K1 are generated on the fly by right-rotating C/D before PC2.
// Optional feature macro DES_DEC_ENC_EN adds an `encrypt` input (sampled at
// accept) that switches the schedule to left rotations, yielding K1..K16.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [64:1] in_block,
  input  logic [64:1] in_key,
`ifdef DES_DEC_ENC_EN
  input  logic        encrypt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [64:1] out_block
);

  state_t      state, state_nxt;
  logic [3:0]  rnd;
  logic [32:1] l_half, r_half;
  logic [28:1] c_half, d_half;
  logic [28:1] c_rot, d_rot;
  logic [1:0]  rot_amt;
  logic [48:1] subkey;
  logic [32:1] f_out;

`ifdef DES_DEC_ENC_EN
  logic enc_mode;
`else
  localparam logic enc_mode = 1'b0;
`endif

  // Key schedule: rotate the current C/D, then select the round subkey.
  assign rot_amt = des_rot_amt(rnd, enc_mode);
  assign c_rot   = enc_mode ? des_rotl(c_half, rot_amt) : des_rotr(c_half, rot_amt);
  assign d_rot   = enc_mode ? des_rotl(d_half, rot_amt) : des_rotr(d_half, rot_amt);
  assign subkey  = des_pc2({c_rot, d_rot});

  des_round_f u_round_f (
    .r      (r_half),
    .subkey (subkey),
    .f      (f_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, 16 rounds in RUN, hold DONE until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)          state_nxt = ST_RUN;
      ST_RUN:  if (rnd == RND_LAST)   state_nxt = ST_DONE;
      ST_DONE: if (out_ready)         state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Final swap and FP are pure wiring on the registered halves.
  assign out_block = des_fp({r_half, l_half});

  // Round datapath: load on accept, one Feistel round per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_half   <= '0;
      r_half   <= '0;
      c_half   <= '0;
      d_half   <= '0;
      rnd      <= 4'd0;
`ifdef DES_DEC_ENC_EN
      enc_mode <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      if (in_valid) begin
        {l_half, r_half} <= des_ip(in_block);
        {c_half, d_half} <= des_pc1(in_key);
        rnd              <= 4'd1;
`ifdef DES_DEC_ENC_EN
        enc_mode         <= encrypt;
`endif
      end
    end else if (state == ST_RUN) begin
      l_half <= r_half;
      r_half <= l_half ^ f_out;
      c_half <= c_rot;
      d_half <= d_rot;
      rnd    <= rnd + 4'd1;
    end
  end

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core: directed bench for the iterative DES core with a
// reference DES model (precomputed key schedule) and a per-cycle checker.
module tb_des_decrypt_core;
  import des_pkg::*;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT0  = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] KEYP = 64'h0101010101010101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_block;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_block;
  bit          enc_drv = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  des_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
`ifdef DES_DEC_ENC_EN
    .encrypt   (enc_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Textbook DES: build K1..K16 with left shifts, then run 16 rounds using
  // the keys forwards (encrypt) or backwards (decrypt).
  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key, input bit enc);
    int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [63:0] v, res;
    logic [31:0] l, r, t, sv, fo;
    logic [47:0] x, k;
    logic [5:0]  six;
    int e;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int j = 0; j < 16; j++) begin
      for (int s = 0; s < shifts[j]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[j][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 64; i++) v[63-i] = blk[64-IP_T[i]];
    l = v[63:32];
    r = v[31:0];
    for (int j = 0; j < 16; j++) begin
      k = enc ? ks[j] : ks[15-j];
      for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
      x = x ^ k;
      for (int b = 0; b < 8; b++) begin
        six = x[47-6*b -: 6];
        e = SBOX_T[b][{six[5], six[0], six[4:1]}];
        sv[31-4*b -: 4] = e[3:0];
      end
      for (int i = 0; i < 32; i++) fo[31-i] = sv[32-P_T[i]];
      t = r;
      r = l ^ fo;
      l = t;
    end
    v = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = v[64-FP_T[i]];
    return res;
  endfunction

  // Transaction-level expectation: a block accepted while idle becomes
  // visible 17 cycles later and is held until out_ready.
  int          ncyc = 0;
  int          acc_ncyc = 0;
  int          last_lat = -1;
  int          acc_log [$];
  logic [63:0] got_q [$];
  bit          m_busy = 1'b0;
  int          m_edges = 0;
  logic [63:0] m_exp = '0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    bit exp_valid;
    ncyc++;
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_block", out_block, 0);
      m_busy  = 1'b0;
      m_edges = 0;
    end else begin
      exp_valid = m_busy && (m_edges >= 16);
      check("in_ready", in_ready, !m_busy);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) check("out_block", out_block, m_exp);
      if (out_valid && !prev_valid) last_lat = ncyc - acc_ncyc;
      if (out_valid && out_ready) got_q.push_back(out_block);
      if (!m_busy) begin
        if (in_valid) begin
          m_busy   = 1'b1;
          m_edges  = 0;
          m_exp    = des_ref(in_block, in_key, enc_drv);
          acc_ncyc = ncyc;
          acc_log.push_back(ncyc);
        end
      end else if (exp_valid && out_ready) begin
        m_busy = 1'b0;
      end else begin
        m_edges++;
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input logic [63:0] blk, input logic [63:0] key, input bit enc, input bit keep);
    int n = 0;
    in_valid = 1'b1;
    in_block = blk;
    in_key   = key;
    enc_drv  = enc;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = keep;
    in_block = {$urandom, $urandom};
    in_key   = {$urandom, $urandom};
  endtask

  task automatic junk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'b1;
      in_block = {$urandom, $urandom};
      in_key   = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_out(input string name, input logic [63:0] exp, input int stall);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_valid"}, out_valid, 1);
    check(name, out_block, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      in_block = {$urandom, $urandom};
      in_key   = {$urandom, $urandom};
      @(posedge clk); #1;
      check({name, "_hold_ready"}, in_ready, 0);
      check({name, "_hold_data"}, out_block, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_idle"}, in_ready, 1);
  endtask

  initial begin
    int base;
    int n;
    in_valid  = 1'b0;
    in_block  = '0;
    in_key    = '0;
    out_ready = 1'b0;

    check("ref_dec_vec1", des_ref(CT1, KEY1, 1'b0), PT1);
    check("ref_dec_zero", des_ref(CT0, 64'h0, 1'b0), 64'h0);
    check("ref_enc_vec1", des_ref(PT1, KEY1, 1'b1), CT1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_block", out_block, 64'h0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(CT1, KEY1, 1'b0, 1'b0);
    expect_out("vec1", PT1, 0);
    check("vec1_latency", last_lat, 17);

    send(CT0, 64'h0, 1'b0, 1'b0);
    junk(5);
    expect_out("zero_key_stall", 64'h0, 10);

    send(CT0, KEYP, 1'b0, 1'b0);
    expect_out("parity_key", 64'h0, 0);

    send(CT1, KEY1, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(CT1, KEY1, 1'b0, 1'b0);
    expect_out("after_abort", PT1, 0);

    base = got_q.size();
    out_ready = 1'b1;
    send(CT1, KEY1, 1'b0, 1'b1);
    send(CT0, KEYP, 1'b0, 1'b0);
    n = 0;
    while (got_q.size() < base + 2 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check("b2b_count", got_q.size(), base + 2);
    if (got_q.size() >= base + 2) begin
      check("b2b_first", got_q[base], PT1);
      check("b2b_second", got_q[base+1], 64'h0);
    end
    check("b2b_spacing", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 18);

`ifdef DES_DEC_ENC_EN
    send(PT1, KEY1, 1'b1, 1'b0);
    expect_out("enc_vec1", CT1, 0);
    send(CT1, KEY1, 1'b0, 1'b0);
    expect_out("dec_after_enc", PT1, 0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
